// File: rtl/led_calib_pkg.sv
// Shared types and constants for the LED calibration write path.
package led_calib_pkg;
   localparam int COLOR_W      = 24;
   localparam int DEF_NUM_LEDS = 50;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_LEDS + 1);

   typedef enum logic [1:0] {SERVE, WIPE_PULSE, WIPE_WAIT, WIPE_BUSY} sched_state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] address;
      logic [COLOR_W-1:0]    color;
   } led_write_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/led_buffer_write_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter; the port not granted last wins a tie.
module rr_arbiter_2 (
   input  logic       clk_pixel,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);
   logic last_a;

   assign grant[0] = req[0] & (~req[1] | ~last_a);
   assign grant[1] = req[1] & (~req[0] |  last_a);

   always_ff @(posedge clk_pixel) begin
      if (rst)         last_a <= 1'b0;
      else if (accept) last_a <= grant[0];
   end
endmodule

// File: rtl/led_buffer_write_scheduler.sv
// Serializes writes from two requesters into the LED buffer and sequences
// buffer wipes; the address parks on an unused slot whenever nothing is written.
module led_buffer_write_scheduler
   import led_calib_pkg::*;
#(
   parameter int NUM_LEDS          = 50,
   parameter int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS + 1),
   parameter int PARK_ADDR         = NUM_LEDS,
   parameter int FBUF_COLOR_WIDTH  = 24,
   parameter int TIMEOUT_CYCLES    = 8
) (
   input  logic                         clk_pixel,
   input  logic                         rst,
   input  logic                         a_valid,
   output logic                         a_ready,
   input  logic [LED_ADDRESS_WIDTH-1:0] a_addr,
   input  logic [FBUF_COLOR_WIDTH-1:0]  a_color,
   input  logic                         b_valid,
   output logic                         b_ready,
   input  logic [LED_ADDRESS_WIDTH-1:0] b_addr,
   input  logic [FBUF_COLOR_WIDTH-1:0]  b_color,
   input  logic                         clear_req,
   output logic                         clear_busy,
   output logic                         clear_done,
   output logic                         clear_err,
   output logic                         wipe,
   input  logic                         wiping,
   output logic [LED_ADDRESS_WIDTH-1:0] led_lookup_address,
   output logic [FBUF_COLOR_WIDTH-1:0]  camera_color,
   output logic                         update_enable,
   output logic                         drop_pulse,
   output logic [15:0]                  writes_a,
   output logic [15:0]                  writes_b,
   output logic [15:0]                  drops
);
   localparam logic [LED_ADDRESS_WIDTH-1:0] PARK  = LED_ADDRESS_WIDTH'(PARK_ADDR);
   localparam logic [LED_ADDRESS_WIDTH-1:0] LIMIT = LED_ADDRESS_WIDTH'(NUM_LEDS);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   sched_state_t  state, state_n;
   logic [TW-1:0] tmo_cnt;
   logic [1:0]    grant;
   logic          serve_open, accept, in_range, timeout, finish;
   led_write_t    wr;

   rr_arbiter_2 u_arb (
      .clk_pixel (clk_pixel),
      .rst       (rst),
      .req       ({b_valid, a_valid}),
      .accept    (accept),
      .grant     (grant)
   );

   // A clear command in the same cycle blocks acceptance so nothing slips in behind the wipe.
   assign serve_open = (state == SERVE) && !clear_req;
   assign a_ready    = serve_open & grant[0];
   assign b_ready    = serve_open & grant[1];
   assign accept     = a_ready | b_ready;
   assign clear_busy = (state != SERVE);

   always_comb begin
      wr.address = a_ready ? a_addr  : b_addr;
      wr.color   = a_ready ? a_color : b_color;
   end
   assign in_range = (wr.address < LIMIT);

   assign timeout = (state == WIPE_WAIT) && !wiping && (tmo_cnt == TMO_LAST);
   assign finish  = (state == WIPE_BUSY) && !wiping;

   always_comb begin
      state_n = state;
      case (state)
         SERVE:      if (clear_req) state_n = WIPE_PULSE;
         WIPE_PULSE: state_n = WIPE_WAIT;
         WIPE_WAIT:  if (wiping) state_n = WIPE_BUSY;
                     else if (timeout) state_n = SERVE;
         WIPE_BUSY:  if (!wiping) state_n = SERVE;
         default:    state_n = SERVE;
      endcase
   end

   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         state      <= SERVE;
         tmo_cnt    <= '0;
         wipe       <= 1'b0;
         clear_done <= 1'b0;
         clear_err  <= 1'b0;
      end else begin
         state      <= state_n;
         tmo_cnt    <= (state == WIPE_WAIT) ? tmo_cnt + 1'b1 : '0;
         wipe       <= (state_n == WIPE_PULSE);
         clear_done <= timeout | finish;
         clear_err  <= timeout;
      end
   end

   // Output stage defaults to the parked, disabled write every cycle.
   always_ff @(posedge clk_pixel) begin
      if (rst) begin
         led_lookup_address <= PARK;
         camera_color       <= '0;
         update_enable      <= 1'b0;
         drop_pulse         <= 1'b0;
         writes_a           <= '0;
         writes_b           <= '0;
         drops              <= '0;
      end else begin
         led_lookup_address <= PARK;
         camera_color       <= '0;
         update_enable      <= 1'b0;
         drop_pulse         <= 1'b0;
         if (accept) begin
            if (in_range) begin
               led_lookup_address <= wr.address;
               camera_color       <= wr.color;
               update_enable      <= 1'b1;
               if (a_ready) writes_a <= sat_inc(writes_a);
               else         writes_b <= sat_inc(writes_b);
            end else begin
               drop_pulse <= 1'b1;
               drops      <= sat_inc(drops);
            end
         end
      end
   end
endmodule

// File: tb/tb_led_buffer_write_scheduler.sv
// Directed bench for the LED buffer write scheduler with a small buffer wipe model.
module tb_led_buffer_write_scheduler;
   logic        clk_pixel = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 0, b_valid = 0, a_ready, b_ready;
   logic [5:0]  a_addr = 0, b_addr = 0;
   logic [23:0] a_color = 0, b_color = 0;
   logic        clear_req = 0, clear_busy, clear_done, clear_err, wipe, wiping;
   logic [5:0]  led_lookup_address;
   logic [23:0] camera_color;
   logic        update_enable, drop_pulse;
   logic [15:0] writes_a, writes_b, drops;

   int n_cmp = 0, n_err = 0, done_cnt;
   logic       model_on = 0;
   logic [7:0] wcnt;

   always #5 clk_pixel = ~clk_pixel;

   led_buffer_write_scheduler dut (
      .clk_pixel(clk_pixel), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_color(a_color),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_color(b_color),
      .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
      .clear_err(clear_err), .wipe(wipe), .wiping(wiping),
      .led_lookup_address(led_lookup_address), .camera_color(camera_color),
      .update_enable(update_enable), .drop_pulse(drop_pulse),
      .writes_a(writes_a), .writes_b(writes_b), .drops(drops)
   );

   // Buffer model: wiping runs for 50 cycles starting the cycle after wipe.
   always_ff @(posedge clk_pixel) begin
      if (rst)                       wcnt <= 8'd0;
      else if (model_on && wipe)     wcnt <= 8'd50;
      else if (wcnt != 0)            wcnt <= wcnt - 8'd1;
   end
   assign wiping = (wcnt != 0);

   task automatic step();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      repeat (3) step();
      chk("rst_addr", 32'(led_lookup_address), 32'd50);
      chk("rst_ue", 32'(update_enable), 32'd0);
      chk("rst_color", 32'(camera_color), 32'd0);
      chk("rst_wipe", 32'(wipe), 32'd0);
      chk("rst_busy", 32'(clear_busy), 32'd0);
      chk("rst_wr_a", 32'(writes_a), 32'd0);
      rst = 0;
      step();

      // A alone
      a_valid = 1; a_addr = 6'd5; a_color = 24'hFF0000;
      #1 chk("a_alone_ready", 32'(a_ready), 32'd1);
      step();
      a_valid = 0;
      #1;
      chk("a_alone_addr", 32'(led_lookup_address), 32'd5);
      chk("a_alone_color", 32'(camera_color), 32'hFF0000);
      chk("a_alone_ue", 32'(update_enable), 32'd1);
      chk("a_alone_cnt", 32'(writes_a), 32'd1);
      step();
      chk("a_alone_park", 32'(led_lookup_address), 32'd50);
      chk("a_alone_ue0", 32'(update_enable), 32'd0);
      chk("a_alone_col0", 32'(camera_color), 32'd0);

      // Round-robin tie from a fresh reset
      rst = 1; step(); rst = 0;
      a_valid = 1; a_addr = 6'd1; b_valid = 1; b_addr = 6'd2; b_color = 24'h00FF00;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_a_ready", 32'(a_ready), 32'(i % 2 == 0));
         chk("rr_b_ready", 32'(b_ready), 32'(i % 2 == 1));
         if (i > 0) chk("rr_addr", 32'(led_lookup_address), (i % 2 == 1) ? 32'd1 : 32'd2);
         step();
      end
      a_valid = 0; b_valid = 0;
      #1;
      chk("rr_last_addr", 32'(led_lookup_address), 32'd2);
      chk("rr_last_ue", 32'(update_enable), 32'd1);
      step();
      chk("rr_wr_a", 32'(writes_a), 32'd2);
      chk("rr_wr_b", 32'(writes_b), 32'd2);

      // Clear with buffer model, A held, second clear at T+10 coalesced
      model_on = 1; a_addr = 6'd7; a_valid = 1; clear_req = 1;
      #1 chk("clr_a_blocked", 32'(a_ready), 32'd0);
      step();
      done_cnt = 0;
      for (int k = 1; k <= 60; k++) begin
         clear_req = (k == 10);
         a_valid   = (k <= 53);
         #1;
         chk("clr_wipe", 32'(wipe), 32'(k == 1));
         chk("clr_busy", 32'(clear_busy), 32'(k <= 52));
         chk("clr_done", 32'(clear_done), 32'(k == 53));
         chk("clr_ue", 32'(update_enable), 32'(k == 54));
         chk("clr_a_ready", 32'(a_ready), 32'(k == 53));
         if (clear_done) done_cnt++;
         step();
      end
      clear_req = 0; a_valid = 0;
      chk("clr_done_once", 32'(done_cnt), 32'd1);

      // Timeout with wiping held low
      model_on = 0; clear_req = 1;
      #1;
      step();
      clear_req = 0;
      for (int k = 1; k <= 11; k++) begin
         a_valid = (k == 11);
         #1;
         chk("tmo_done", 32'(clear_done), 32'(k == 10));
         chk("tmo_err", 32'(clear_err), 32'(k == 10));
         chk("tmo_busy", 32'(clear_busy), 32'(k <= 9));
         if (k == 11) chk("tmo_serve", 32'(a_ready), 32'd1);
         step();
      end
      a_valid = 0;

      // Out-of-range drop from B
      b_valid = 1; b_addr = 6'd60;
      #1 chk("drop_ready", 32'(b_ready), 32'd1);
      step();
      b_valid = 0;
      #1;
      chk("drop_pulse", 32'(drop_pulse), 32'd1);
      chk("drop_cnt", 32'(drops), 32'd1);
      chk("drop_ue", 32'(update_enable), 32'd0);
      chk("drop_addr", 32'(led_lookup_address), 32'd50);
      chk("drop_wr_b", 32'(writes_b), 32'd2);
      step();
      chk("drop_pulse_end", 32'(drop_pulse), 32'd0);

      // Reset mid-wipe, after an A grant so the pointer reset is visible
      a_valid = 1; a_addr = 6'd3;
      #1;
      step();
      a_valid = 0; model_on = 1; clear_req = 1;
      #1;
      step();
      clear_req = 0;
      #1 chk("mid_wipe", 32'(wipe), 32'd1);
      step();
      step();
      chk("mid_wiping", 32'(wiping), 32'd1);
      rst = 1;
      #1;
      step();
      chk("mrst_wipe", 32'(wipe), 32'd0);
      chk("mrst_busy", 32'(clear_busy), 32'd0);
      chk("mrst_addr", 32'(led_lookup_address), 32'd50);
      chk("mrst_drops", 32'(drops), 32'd0);
      rst = 0;
      a_valid = 1; b_valid = 1;
      #1;
      chk("mrst_rr_a", 32'(a_ready), 32'd1);
      chk("mrst_rr_b", 32'(b_ready), 32'd0);
      step();
      a_valid = 0; b_valid = 0;
      #1;
      chk("mrst_write", 32'(led_lookup_address), 32'd3);
      chk("mrst_ue", 32'(update_enable), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/led_buffer_write_scheduler.md
# led_buffer_write_scheduler

Sequences all writes into the LED color buffer on the `clk_pixel` domain. It arbitrates round-robin between two write requesters, the camera calibration sampler (port A) and the pattern/host writer (port B), and runs buffer clears through the buffer's `wipe`/`wiping` protocol. The buffer writes every cycle and stores zero whenever `update_enable` is low, so this block also parks the write address on an unused slot whenever no write is in flight.

## Interface
- `NUM_LEDS`, 50: number of valid LED slots.
- `LED_ADDRESS_WIDTH`, `$clog2(NUM_LEDS+1)`: address width. The buffer instance uses the same width, so `PARK_ADDR` is representable.
- `PARK_ADDR`, `NUM_LEDS`: address driven while idle. Must be ≥ `NUM_LEDS`.
- `FBUF_COLOR_WIDTH`, 24: color width, RGB888.
- `TIMEOUT_CYCLES`, 8: maximum wait for `wiping` to rise after `wipe`.

Ports:
- `clk_pixel` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `a_valid`, `b_valid` in 1 each: write requests.
- `a_ready`, `b_ready` out 1 each: request accepted this cycle.
- `a_addr`, `b_addr` in `LED_ADDRESS_WIDTH`: target LED.
- `a_color`, `b_color` in `FBUF_COLOR_WIDTH`: color to write.
- `clear_req` in 1: single-cycle clear command.
- `clear_busy` out 1: high from acceptance of a clear until `clear_done`.
- `clear_done` out 1: one-cycle pulse when a clear completes.
- `clear_err` out 1: one-cycle pulse alongside `clear_done` on timeout.
- `wipe` out 1: to buffer.
- `wiping` in 1: from buffer.
- `led_lookup_address` out `LED_ADDRESS_WIDTH`: to buffer.
- `camera_color` out `FBUF_COLOR_WIDTH`: to buffer.
- `update_enable` out 1: to buffer.
- `drop_pulse` out 1: an accepted request had an address ≥ `NUM_LEDS`.
- `writes_a`, `writes_b`, `drops` out 16 each: saturating counters.

## Operation
- **State machine:** SERVE, WIPE_PULSE, WIPE_WAIT, WIPE_BUSY.
  - SERVE: `clear_req` goes to WIPE_PULSE.
  - WIPE_PULSE: always goes to WIPE_WAIT.
  - WIPE_WAIT: `wiping` high goes to WIPE_BUSY. `TIMEOUT_CYCLES` elapsed without `wiping` goes to SERVE with `clear_err`.
  - WIPE_BUSY: `wiping` low goes to SERVE with `clear_done`.
- **Ready:** `x_ready` is combinational. It requires state SERVE, `clear_req` low, `x_valid` high, and this port winning arbitration.
  - A request held together with `clear_req` is not accepted. It waits until the clear completes.
- **Arbitration:** 2-way round-robin. The port not granted last wins a tie. A lone valid request always wins. After reset, A has priority.
- **Transfer:** `valid && ready` registers the address and color into the output stage, with `update_enable` = 1 for exactly one cycle.
  - If the address is ≥ `NUM_LEDS`: `update_enable` stays 0, the address stays at `PARK_ADDR`, `drop_pulse` fires, and `drops` increments.
- **Idle:** `led_lookup_address` = `PARK_ADDR`, `camera_color` = 0, `update_enable` = 0. This prevents zero-writes to live slots.
- **Clears:**
  - `clear_req` during WIPE_* states is ignored (coalesced). `clear_busy` stays high.
  - `wipe` is a registered output, high only in the WIPE_PULSE cycle.
- **Counters:** increment on accepted in-range writes and saturate at 0xFFFF.
- **Reset:** mid-operation reset returns to SERVE. All outputs go to 0, except `led_lookup_address` = `PARK_ADDR`. Round-robin pointer returns to A.

## Timing
- Handshake at cycle T → buffer write inputs valid in T+1. Throughput is one write per cycle.
- Clear, with `clear_req` sampled in SERVE at cycle T:
  - `wipe` = 1 in T+1.
  - `wiping` is high T+2..T+NUM_LEDS+1. The FSM enters WIPE_BUSY at T+3.
  - `clear_done` pulses and ready can return at T+NUM_LEDS+3. This is T+53 for 50 LEDs.
- `clear_busy` is high T+1 through T+NUM_LEDS+2.
- A write handshaked at T-1 still drives the buffer in T. It lands before `wipe`, and the wipe then zeroes it.
- The output stage never holds `update_enable` = 1 while `wipe` or `wiping` is high.

## Structure
- The shared package `led_calib_pkg` holds:
  - the `sched_state_t` enum;
  - a `led_write_t` struct (address, color);
  - the `COLOR_W` = 24 constant.
- Sub-module `rr_arbiter_2`: two requests, grant one-hot, pointer update on accept.

## Test plan
- A writes addr 5 color 0xFF0000 alone → T+1: `led_lookup_address` = 5, `camera_color` = 0xFF0000, `update_enable` = 1; T+2: address back to `PARK_ADDR` (50).
- A and B both valid for 4 cycles (A addr 1, B addr 2) → grants A, B, A, B; `writes_a` = `writes_b` = 2.
- `clear_req` pulse with a behavioral buffer model → `wipe` one cycle at T+1; `clear_done` at T+53; `clear_busy` high 52 cycles; no `update_enable` during that span; `a_ready` low throughout with `a_valid` held.
- Second `clear_req` at T+10 → ignored; exactly one `clear_done`.
- `wiping` tied low → `clear_done` and `clear_err` pulse at T+10; FSM returns to SERVE.
- B writes addr 60 → `b_ready` = 1, `drop_pulse` = 1, `drops` = 1, `update_enable` stays 0. `rst` asserted mid-wipe → next cycle SERVE, `wipe` = 0, `clear_busy` = 0.
